// File: rtl/core_buffer_exchange.sv
// Shared slot table and release barrier for the SAD core array.
// Optional watchdog: define BUF_XCHG_TIMEOUT_EN to build it.
module core_buffer_exchange #(
  parameter int NUM_CORES = 4,
  parameter int SLOTS     = 2*NUM_CORES,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_CORES-1:0]      active_mask,
  input  logic [32*NUM_CORES-1:0]   buf_val_1_bus,
  input  logic [32*NUM_CORES-1:0]   buf_val_2_bus,
  input  logic [NUM_CORES-1:0]      buf_flag_bus,
  input  logic [5*NUM_CORES-1:0]    buf_val_1_addr_bus,
  input  logic [5*NUM_CORES-1:0]    buf_val_2_addr_bus,
  output logic [32*NUM_CORES-1:0]   buf_val_1_select_bus,
  output logic [32*NUM_CORES-1:0]   buf_val_2_select_bus,
  output logic                      all_buf_flags,
  output logic [NUM_CORES-1:0]      arrived,
  output logic [7:0]                generation,
  output logic                      timeout
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_RELEASE = 1'b1
  } state_e;

  localparam logic [NUM_CORES-1:0] NONE = {NUM_CORES{1'b0}};

  if (NUM_CORES < 1 || NUM_CORES > 16 || SLOTS != 2*NUM_CORES || TIMEOUT < 2) begin : g_bad_param
    $error("core_buffer_exchange: illegal NUM_CORES/SLOTS/TIMEOUT");
  end

  state_e                 state_q, state_d;
  logic [31:0]            table_q [SLOTS];
  logic [31:0]            table_d [SLOTS];
  logic [NUM_CORES-1:0]   arrived_q, arrived_d;
  logic [NUM_CORES-1:0]   capture_s, force_s;
  logic                   all_flags_q, all_flags_d;
  logic [7:0]             gen_q, gen_d;
  logic                   complete_s;
  logic [31:0]            rd_table_s [32];

`ifdef BUF_XCHG_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT-1);
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   timeout_q, timeout_d;
`endif

  // State register: reset wins over every capture and release.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_COLLECT;
      arrived_q   <= NONE;
      all_flags_q <= 1'b0;
      gen_q       <= 8'd0;
      for (int k = 0; k < SLOTS; k++) begin
        table_q[k] <= 32'h0;
      end
`ifdef BUF_XCHG_TIMEOUT_EN
      wd_q        <= {WD_W{1'b0}};
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      arrived_q   <= arrived_d;
      all_flags_q <= all_flags_d;
      gen_q       <= gen_d;
      for (int k = 0; k < SLOTS; k++) begin
        table_q[k] <= table_d[k];
      end
`ifdef BUF_XCHG_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state logic: barrier sequencing, captures and forced release.
  always_comb begin
    state_d     = state_q;
    arrived_d   = arrived_q;
    all_flags_d = all_flags_q;
    gen_d       = gen_q;
    capture_s   = NONE;
    force_s     = NONE;
    complete_s  = 1'b0;
`ifdef BUF_XCHG_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        capture_s  = buf_flag_bus & ~arrived_q & active_mask;
        arrived_d  = arrived_q | capture_s;
        complete_s = &(arrived_d | ~active_mask);
        if (complete_s) begin
          state_d     = ST_RELEASE;
          all_flags_d = 1'b1;
`ifdef BUF_XCHG_TIMEOUT_EN
          wd_d        = {WD_W{1'b0}};
`endif
        end
`ifdef BUF_XCHG_TIMEOUT_EN
        // The watchdog only runs once somebody is actually waiting.
        else if (arrived_q != NONE) begin
          if (wd_q == WD_LAST) begin
            force_s     = active_mask & ~arrived_d;
            state_d     = ST_RELEASE;
            all_flags_d = 1'b1;
            timeout_d   = 1'b1;
            wd_d        = {WD_W{1'b0}};
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end else begin
          wd_d = wd_q;
        end
`else
        else begin
          state_d = ST_COLLECT;
        end
`endif
      end
      ST_RELEASE: begin
        if ((buf_flag_bus & active_mask) == NONE) begin
          state_d     = ST_COLLECT;
          all_flags_d = 1'b0;
          arrived_d   = NONE;
          gen_d       = gen_q + 8'd1;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d     = ST_COLLECT;
        all_flags_d = 1'b0;
      end
    endcase

    for (int i = 0; i < NUM_CORES; i++) begin
      if (capture_s[i]) begin
        table_d[2*i]   = buf_val_1_bus[32*i +: 32];
        table_d[2*i+1] = buf_val_2_bus[32*i +: 32];
      end else if (force_s[i]) begin
        table_d[2*i]   = 32'h0;
        table_d[2*i+1] = 32'h0;
      end else begin
        table_d[2*i]   = table_q[2*i];
        table_d[2*i+1] = table_q[2*i+1];
      end
    end
  end

  // Pad the table to the full 5-bit address space so out-of-range reads give zero.
  for (genvar j = 0; j < 32; j++) begin : g_rd_pad
    if (j < SLOTS) begin : g_slot
      assign rd_table_s[j] = table_q[j];
    end else begin : g_zero
      assign rd_table_s[j] = 32'h0;
    end
  end

  // Output logic: zero-latency reads of the registered table.
  always_comb begin
    buf_val_1_select_bus = {(32*NUM_CORES){1'b0}};
    buf_val_2_select_bus = {(32*NUM_CORES){1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      buf_val_1_select_bus[32*i +: 32] = rd_table_s[buf_val_1_addr_bus[5*i +: 5]];
      buf_val_2_select_bus[32*i +: 32] = rd_table_s[buf_val_2_addr_bus[5*i +: 5]];
    end
  end

  assign all_buf_flags = all_flags_q;
  assign arrived       = arrived_q;
  assign generation    = gen_q;
`ifdef BUF_XCHG_TIMEOUT_EN
  assign timeout       = timeout_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_core_buffer_exchange.sv
// Bench for core_buffer_exchange: directed scenarios plus a random run
// checked against a behavioural barrier/table model.
module tb_core_buffer_exchange;

  localparam int NC = 4;
  localparam int SL = 2*NC;
  localparam int TO = 8;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic            Reset;
  logic [NC-1:0]   mask, flag;
  logic [31:0]     v1 [NC];
  logic [31:0]     v2 [NC];
  logic [4:0]      a1 [NC];
  logic [4:0]      a2 [NC];
  logic [32*NC-1:0] v1_bus, v2_bus, sel1, sel2;
  logic [5*NC-1:0]  a1_bus, a2_bus;
  logic            rel;
  logic [NC-1:0]   arr;
  logic [7:0]      gen;
  logic            tmo;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      v1_bus[32*i +: 32] = v1[i];
      v2_bus[32*i +: 32] = v2[i];
      a1_bus[5*i +: 5]   = a1[i];
      a2_bus[5*i +: 5]   = a2[i];
    end
  end

  core_buffer_exchange #(.NUM_CORES(NC), .SLOTS(SL), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .active_mask(mask),
    .buf_val_1_bus(v1_bus), .buf_val_2_bus(v2_bus), .buf_flag_bus(flag),
    .buf_val_1_addr_bus(a1_bus), .buf_val_2_addr_bus(a2_bus),
    .buf_val_1_select_bus(sel1), .buf_val_2_select_bus(sel2),
    .all_buf_flags(rel), .arrived(arr), .generation(gen), .timeout(tmo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: slot table plus barrier bookkeeping.
  logic [31:0] m_tab [SL];
  logic [NC-1:0] m_arr;
  bit m_rel, m_to;
  int m_gen, m_wd;

  task automatic model_edge();
    logic [NC-1:0] na;
    bit done;
    if (Reset) begin
      for (int k = 0; k < SL; k++) m_tab[k] = 32'h0;
      m_arr = '0; m_rel = 0; m_gen = 0; m_to = 0; m_wd = 0;
    end else if (!m_rel) begin
      na = m_arr;
      for (int i = 0; i < NC; i++)
        if (flag[i] && mask[i] && !m_arr[i]) begin
          m_tab[2*i] = v1[i]; m_tab[2*i+1] = v2[i]; na[i] = 1'b1;
        end
      done = 1;
      for (int i = 0; i < NC; i++) if (mask[i] && !na[i]) done = 0;
      if (done) begin
        m_rel = 1; m_wd = 0;
      end
`ifdef BUF_XCHG_TIMEOUT_EN
      else if (m_arr != '0) begin
        if (m_wd == TO-1) begin
          for (int i = 0; i < NC; i++)
            if (mask[i] && !na[i]) begin m_tab[2*i] = 32'h0; m_tab[2*i+1] = 32'h0; end
          m_to = 1; m_rel = 1; m_wd = 0;
        end else m_wd++;
      end
`endif
      m_arr = na;
    end else begin
      done = 1;
      for (int i = 0; i < NC; i++) if (mask[i] && flag[i]) done = 0;
      if (done) begin m_rel = 0; m_arr = '0; m_gen = (m_gen + 1) % 256; end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; mask = '0; flag = '0;
    for (int i = 0; i < NC; i++) begin v1[i] = 32'h0; v2[i] = 32'h0; a1[i] = 5'd0; a2[i] = 5'd0; end
    step(); step();
    Reset = 1'b0;
    #1;
    n_cmp++; if (arr !== 4'b0000 || rel !== 1'b0 || gen !== 8'd0 || tmo !== 1'b0) begin
      n_bad++; $display("FAIL reset: arr=%b rel=%b gen=%0d tmo=%b expected 0/0/0/0", arr, rel, gen, tmo);
    end
    for (int s = 0; s < SL; s++) begin
      a1[0] = 5'(s); #1;
      n_cmp++; if (sel1[31:0] !== 32'h0) begin n_bad++; $display("FAIL reset_slot%0d: got %h expected 0", s, sel1[31:0]); end
    end
  endtask

  task automatic test_collect();
    mask = 4'hF;
    for (int i = 0; i < NC; i++) begin v1[i] = 32'h100 + 32'(i); v2[i] = 32'h200 + 32'(i); end
    flag[0] = 1'b1; step();
    n_cmp++; if (arr !== 4'b0001 || rel !== 1'b0) begin n_bad++; $display("FAIL arrive1: arr=%b rel=%b expected 0001/0", arr, rel); end
    step();
    flag[1] = 1'b1; flag[2] = 1'b1; step();
    n_cmp++; if (arr !== 4'b0111 || rel !== 1'b0) begin n_bad++; $display("FAIL arrive3: arr=%b rel=%b expected 0111/0", arr, rel); end
    step(); step();
    flag[3] = 1'b1; step();
    n_cmp++; if (arr !== 4'b1111 || rel !== 1'b1 || gen !== 8'd0) begin
      n_bad++; $display("FAIL release: arr=%b rel=%b gen=%0d expected 1111/1/0", arr, rel, gen);
    end
    a1[1] = 5'd5; #1;
    n_cmp++; if (sel1[63:32] !== 32'h202) begin n_bad++; $display("FAIL slot5: got %h expected 202", sel1[63:32]); end
  endtask

  task automatic test_frozen();
    v1[2] = 32'hDEAD; v1[0] = 32'h111; step();
    a1[0] = 5'd4; a2[3] = 5'd31; #1;
    n_cmp++; if (rel !== 1'b1 || sel1[31:0] !== 32'h102) begin n_bad++; $display("FAIL frozen4: rel=%b slot4=%h expected 1/102", rel, sel1[31:0]); end
    n_cmp++; if (sel2[127:96] !== 32'h0) begin n_bad++; $display("FAIL addr31: got %h expected 0", sel2[127:96]); end
    a1[0] = 5'd0; #1;
    n_cmp++; if (sel1[31:0] !== 32'h100) begin n_bad++; $display("FAIL frozen0: got %h expected 100", sel1[31:0]); end
  endtask

  task automatic test_release_exit();
    // Core 0 keeps its flag up but sits out the exit edge, then rejoins.
    mask = 4'b1110; flag = 4'b0001; step();
    n_cmp++; if (rel !== 1'b0 || arr !== 4'b0000 || gen !== 8'd1) begin
      n_bad++; $display("FAIL exit: rel=%b arr=%b gen=%0d expected 0/0000/1", rel, arr, gen);
    end
    mask = 4'hF; step();
    a1[0] = 5'd0; #1;
    n_cmp++; if (arr !== 4'b0001 || sel1[31:0] !== 32'h111) begin
      n_bad++; $display("FAIL recapture: arr=%b slot0=%h expected 0001/111", arr, sel1[31:0]);
    end
  endtask

  task automatic test_mask();
    logic [31:0] exp_s [4];
    mask = 4'b0101; flag = 4'b0111; v1[1] = 32'hBEEF; step();
    n_cmp++; if (rel !== 1'b1 || arr !== 4'b0101) begin n_bad++; $display("FAIL mask_rel: rel=%b arr=%b expected 1/0101", rel, arr); end
    exp_s[0] = 32'h101; exp_s[1] = 32'h201; exp_s[2] = 32'h103; exp_s[3] = 32'h203;
    for (int k = 0; k < 4; k++) begin
      a1[0] = (k < 2) ? 5'(2 + k) : 5'(4 + k); #1;
      n_cmp++; if (sel1[31:0] !== exp_s[k]) begin n_bad++; $display("FAIL mask_slot%0d: got %h expected %h", a1[0], sel1[31:0], exp_s[k]); end
    end
    a1[0] = 5'd4; #1;
    n_cmp++; if (sel1[31:0] !== 32'hDEAD) begin n_bad++; $display("FAIL mask_slot4: got %h expected dead", sel1[31:0]); end
    flag = '0; step();
    n_cmp++; if (rel !== 1'b0 || gen !== 8'd2) begin n_bad++; $display("FAIL mask_exit: rel=%b gen=%0d expected 0/2", rel, gen); end
  endtask

  task automatic test_reset_mid();
    mask = 4'hF; flag = 4'b0011; step();
    n_cmp++; if (arr !== 4'b0011) begin n_bad++; $display("FAIL mid_arr: got %b expected 0011", arr); end
    flag = 4'b0111; Reset = 1'b1; step();
    Reset = 1'b0; flag = '0; #1;
    n_cmp++; if (arr !== 4'b0000 || rel !== 1'b0 || gen !== 8'd0) begin
      n_bad++; $display("FAIL mid_reset: arr=%b rel=%b gen=%0d expected 0/0/0", arr, rel, gen);
    end
    for (int s = 0; s < SL; s++) begin
      a2[1] = 5'(s); #1;
      n_cmp++; if (sel2[63:32] !== 32'h0) begin n_bad++; $display("FAIL mid_slot%0d: got %h expected 0", s, sel2[63:32]); end
    end
  endtask

  task automatic test_timeout();
    int n;
    mask = 4'hF; flag = 4'hF;
    for (int i = 0; i < NC; i++) begin v1[i] = 32'h500 + 32'(i); v2[i] = 32'h600 + 32'(i); end
    step(); flag = '0; step();
    v1[0] = 32'hAAAA; flag = 4'b0001; step();
    n = 0;
    while (rel !== 1'b1 && n < 100) begin step(); n++; end
`ifdef BUF_XCHG_TIMEOUT_EN
    n_cmp++; if (rel !== 1'b1 || n != TO || tmo !== 1'b1) begin
      n_bad++; $display("FAIL wd_fire: rel=%b cycles=%0d tmo=%b expected 1/%0d/1", rel, n, tmo, TO);
    end
    for (int s = 0; s < SL; s++) begin
      a1[2] = 5'(s); #1;
      n_cmp++; if (sel1[95:64] !== ((s == 0) ? 32'hAAAA : (s == 1) ? 32'h600 : 32'h0)) begin
        n_bad++; $display("FAIL wd_slot%0d: got %h", s, sel1[95:64]);
      end
    end
    flag = '0; step();
    n_cmp++; if (rel !== 1'b0 || tmo !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: rel=%b tmo=%b expected 0/1", rel, tmo); end
`else
    a1[2] = 5'd2; #1;
    n_cmp++; if (rel !== 1'b0 || n != 100 || tmo !== 1'b0 || sel1[95:64] !== 32'h501) begin
      n_bad++; $display("FAIL no_wd: rel=%b cycles=%0d tmo=%b slot2=%h expected 0/100/0/501", rel, n, tmo, sel1[95:64]);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    Reset = 1'b1; step(); Reset = 1'b0;
    mask = 4'hF; flag = '0;
    for (int c = 0; c < 800; c++) begin
      Reset = ($urandom_range(99) == 0);
      if ($urandom_range(11) == 0) mask = 4'($urandom);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(3) == 0) flag[i] = ~flag[i];
        v1[i] = $urandom; v2[i] = $urandom;
        a1[i] = 5'($urandom_range(SL + 1)); a2[i] = 5'($urandom);
      end
      step();
      n_cmp++; if (arr !== m_arr || rel !== m_rel || gen !== 8'(m_gen) || tmo !== m_to) begin
        n_bad++; $display("FAIL rnd_state c=%0d: arr=%b rel=%b gen=%0d tmo=%b expected %b/%b/%0d/%b",
                          c, arr, rel, gen, tmo, m_arr, m_rel, m_gen, m_to);
      end
      for (int i = 0; i < NC; i++) begin
        e1 = (a1[i] < SL) ? m_tab[a1[i]] : 32'h0;
        e2 = (a2[i] < SL) ? m_tab[a2[i]] : 32'h0;
        n_cmp++; if (sel1[32*i +: 32] !== e1 || sel2[32*i +: 32] !== e2) begin
          n_bad++; $display("FAIL rnd_read c=%0d core%0d: got %h/%h expected %h/%h", c, i, sel1[32*i +: 32], sel2[32*i +: 32], e1, e2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_collect();
    test_frozen();
    test_release_exit();
    test_mask();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
